network_rx_buffer: RTL and testbench
====================================

NETWORK_RX_BUFFER -- requirements
Module: network_rx_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512: width of one network line beat.
REQ-002 SHALL have parameter LOG_DEPTH, default 4: FIFO depth = 2^LOG_DEPTH entries.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port net_valid  input  1  network line beat present; the line has no backpressure.
REQ-006 SHALL have port net_data  input  DATA_WIDTH  network line beat payload.
REQ-007 SHALL have port out_valid  output  1  head entry available to the consumer.
REQ-008 SHALL have port out_data  output  DATA_WIDTH  head entry payload.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-010 SHALL have port fill_level  output  LOG_DEPTH+1  current number of stored entries.
REQ-011 SHALL have port overflow  output  1  sticky flag, set when a beat has been dropped.
REQ-012 SHALL have port drop_cnt  output  32  dropped-beat counter, present only under NET_RX_STATS_EN.

Function
REQ-013 SHALL write net_data into the FIFO tail on every cycle where net_valid=1 and the write is accepted.
REQ-014 SHALL accept a write when fill_level < 2^LOG_DEPTH, or when fill_level = 2^LOG_DEPTH and a pop occurs in the same cycle.
REQ-015 SHALL drop the beat when fill_level = 2^LOG_DEPTH and no pop occurs in that cycle; FIFO contents stay unchanged.
REQ-016 SHALL define a pop as out_valid=1 and out_ready=1 in the same cycle.
REQ-017 SHALL drive out_valid=1 exactly when fill_level > 0, and SHALL drive out_data as the head entry (show-ahead).
REQ-018 SHALL give one-cycle latency: a beat accepted in cycle N is visible on out_valid/out_data in cycle N+1 if the FIFO was empty.
REQ-019 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-020 SHALL update fill_level on push only: +1; on pop only: -1; on push and pop together: unchanged.
REQ-021 SHALL wrap head and tail pointers modulo 2^LOG_DEPTH with no bubble at the wrap.
REQ-022 SHALL ignore out_ready when out_valid=0; this is no pop and no underflow.
REQ-023 SHALL set overflow on the first dropped beat and hold it until reset.
REQ-024 SHALL preserve beat order exactly: no reordering and no duplication.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, clear pointers and set fill_level=0, out_valid=0, overflow=0, drop_cnt=0.
REQ-026 SHALL discard the net_valid beat arriving in a reset cycle and SHALL NOT count it as a drop.
REQ-027 SHALL, when reset occurs mid-operation, discard all stored entries; out_data content is don't-care while out_valid=0.

Configuration
REQ-028 SHALL, with NET_RX_STATS_EN defined, implement drop_cnt, incrementing by 1 per dropped beat and saturating at 32'hFFFFFFFF.
REQ-029 SHALL, without NET_RX_STATS_EN, omit the drop_cnt port and counter; all other behaviour is identical.

Verification
REQ-030 SHALL cover single beat: empty FIFO, net_valid=1 with data 0xA5 in cycle 0, out_ready=1 -> out_valid=1 and out_data=0xA5 in cycle 1, fill_level returns to 0 in cycle 2.
REQ-031 SHALL cover fill and drop: 18 back-to-back beats 1..18, out_ready=0 -> fill_level=16; beats 17 and 18 dropped; overflow=1; drop_cnt=2 (with macro); draining yields 1..16.
REQ-032 SHALL cover full with simultaneous pop: full FIFO, net_valid=1 and out_ready=1 in the same cycle -> beat accepted, fill_level stays 16, drop_cnt unchanged.
REQ-033 SHALL cover wrap: 40 beats streamed with out_ready toggling 1/0 every cycle -> every beat is received in order with no drops and pointers wrap at least twice.
REQ-034 SHALL cover reset mid-operation: 5 entries stored, overflow=1, reset for 1 cycle -> next cycle fill_level=0, out_valid=0, overflow=0, drop_cnt=0.
REQ-035 SHALL cover the build without NET_RX_STATS_EN: rerun REQ-031 -> identical data and overflow behaviour, and no drop_cnt port present.

Source files
------------

// File: rtl/network_rx_buffer.sv
// rtl/network_rx_buffer.sv - show-ahead receive FIFO for a network line without backpressure
// Optional feature macro: NET_RX_STATS_EN (adds the saturating drop_cnt output).
module network_rx_buffer #(
    parameter int DATA_WIDTH = 512,
    parameter int LOG_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  net_valid,
    input  logic [DATA_WIDTH-1:0] net_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [LOG_DEPTH:0]    fill_level,
    output logic                  overflow
`ifdef NET_RX_STATS_EN
    ,
    output logic [31:0]           drop_cnt
`endif
);

    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH-1:0] PTR_ONE = LOG_DEPTH'(1);
    localparam logic [LOG_DEPTH:0]   CNT_ONE = (LOG_DEPTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [LOG_DEPTH-1:0]  head_q, head_d;
    logic [LOG_DEPTH-1:0]  tail_q, tail_d;
    logic [LOG_DEPTH:0]    count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic pop;
    logic push;
    logic drop;
    logic full;

    // The count never exceeds DEPTH, so its top bit alone marks a full FIFO.
    assign full       = count_q[LOG_DEPTH];
    assign out_valid  = (count_q != '0);
    assign out_data   = mem_q[head_q];
    assign fill_level = count_q;
    assign overflow   = overflow_q;

    // A full FIFO still takes a beat when the head leaves in the same cycle.
    assign pop  = out_valid & out_ready;
    assign push = net_valid & (~full | pop);
    assign drop = net_valid & full & ~pop;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (pop) begin
            head_d = head_q + PTR_ONE;
        end
        if (push) begin
            tail_d = tail_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // Control state registers; the beat seen during reset is simply discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage has no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[tail_q] <= net_data;
        end
    end

`ifdef NET_RX_STATS_EN
    logic [31:0] drop_cnt_q, drop_cnt_d;

    assign drop_cnt = drop_cnt_q;

    // Dropped-beat count sticks at all-ones rather than wrapping back to zero.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_network_rx_buffer.sv
// tb/tb_network_rx_buffer.sv - randomized self-checking bench for network_rx_buffer
module tb_network_rx_buffer;

    localparam int DW    = 512;
    localparam int LD    = 4;
    localparam int DEPTH = 1 << LD;

    logic          clk = 1'b0;
    logic          reset;
    logic          net_valid;
    logic [DW-1:0] net_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [LD:0]   fill_level;
    logic          overflow;
`ifdef NET_RX_STATS_EN
    logic [31:0]   drop_cnt;
`endif

    network_rx_buffer #(.DATA_WIDTH(DW), .LOG_DEPTH(LD)) dut (
        .clk        (clk),
        .reset      (reset),
        .net_valid  (net_valid),
        .net_data   (net_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .fill_level (fill_level),
        .overflow   (overflow)
`ifdef NET_RX_STATS_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: an ordered list of stored beats plus sticky flag and drop tally.
    logic [DW-1:0] mq[$];
    logic          m_ovf;
    logic [31:0]   m_drops;

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // One clock with the given inputs; the model applies the FIFO rules for that cycle.
    task automatic cycle(input logic nv, input logic [DW-1:0] nd, input logic rdy);
        bit pop, acc;
        net_valid = nv;
        net_data  = nd;
        out_ready = rdy;
        pop = (mq.size() > 0) && rdy;
        acc = nv && ((mq.size() < DEPTH) || pop);
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(nd);
        if (nv && !acc) begin
            m_ovf = 1'b1;
            if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 32'd1;
        end
    endtask

    // Reset cycle, optionally with a beat arriving that must be discarded.
    task automatic do_reset(input logic nv);
        reset     = 1'b1;
        net_valid = nv;
        net_data  = rand_data();
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        net_valid = 1'b0;
        mq.delete();
        m_ovf   = 1'b0;
        m_drops = 32'd0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        n_checks++; if (fill_level !== 5'd0) $display("FAIL reset_fill got %0d want 0", fill_level); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else n_pass++;
`ifdef NET_RX_STATS_EN
        n_checks++; if (drop_cnt !== 32'd0) $display("FAIL reset_dropcnt got %0d want 0", drop_cnt); else n_pass++;
`endif
        cycle(1'b0, '0, 1'b1);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_beat_discarded valid got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_single_beat();
        do_reset(1'b0);
        cycle(1'b1, DW'(8'hA5), 1'b1);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== DW'(8'hA5)) $display("FAIL single_data got %h want a5", out_data[31:0]); else n_pass++;
        n_checks++; if (fill_level !== 5'd1) $display("FAIL single_fill1 got %0d want 1", fill_level); else n_pass++;
        cycle(1'b0, '0, 1'b1);
        n_checks++; if (fill_level !== 5'd0) $display("FAIL single_fill2 got %0d want 0", fill_level); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_valid2 got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_fill_drop();
        do_reset(1'b0);
        for (int i = 1; i <= 18; i++) cycle(1'b1, DW'(i), 1'b0);
        n_checks++; if (fill_level !== 5'd16) $display("FAIL fill_level got %0d want 16", fill_level); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL fill_ovf got %b want 1", overflow); else n_pass++;
`ifdef NET_RX_STATS_EN
        n_checks++; if (drop_cnt !== 32'd2) $display("FAIL fill_dropcnt got %0d want 2", drop_cnt); else n_pass++;
`endif
        for (int i = 1; i <= 16; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== DW'(i)) $display("FAIL drain_data got %0d/%0d want 1/%0d", out_valid, out_data[31:0], i); else n_pass++;
            cycle(1'b0, '0, 1'b1);
        end
        n_checks++; if (out_valid !== 1'b0) $display("FAIL drain_empty got %b want 0", out_valid); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else n_pass++;
    endtask

    task automatic test_full_pop();
        do_reset(1'b0);
        for (int i = 1; i <= 16; i++) cycle(1'b1, DW'(i + 100), 1'b0);
        // Stable head while stalled.
        n_checks++; if (out_data !== DW'(101)) $display("FAIL stall_head got %0d want 101", out_data[31:0]); else n_pass++;
        cycle(1'b1, DW'(200), 1'b1);
        n_checks++; if (fill_level !== 5'd16) $display("FAIL fullpop_fill got %0d want 16", fill_level); else n_pass++;
        n_checks++; if (out_data !== DW'(102)) $display("FAIL fullpop_head got %0d want 102", out_data[31:0]); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL fullpop_ovf got %b want 0", overflow); else n_pass++;
`ifdef NET_RX_STATS_EN
        n_checks++; if (drop_cnt !== 32'd0) $display("FAIL fullpop_dropcnt got %0d want 0", drop_cnt); else n_pass++;
`endif
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
        n_checks++; if (fill_level !== 5'd0) $display("FAIL fullpop_drain got %0d want 0", fill_level); else n_pass++;
    endtask

    task automatic test_wrap();
        int sent = 0;
        int expect_next = 1;
        int cyc = 0;
        do_reset(1'b0);
        while (expect_next <= 40 && cyc < 400) begin
            logic nv, rdy;
            nv  = (cyc % 2 == 0) && (sent < 40);
            rdy = (cyc % 2 == 0);
            if (out_valid && rdy) begin
                n_checks++; if (out_data !== DW'(expect_next)) $display("FAIL wrap_order got %0d want %0d", out_data[31:0], expect_next); else n_pass++;
                expect_next++;
            end
            if (nv) sent++;
            cycle(nv, DW'(sent), rdy);
            cyc++;
        end
        n_checks++; if (expect_next !== 41) $display("FAIL wrap_count got %0d want 41", expect_next); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL wrap_ovf got %b want 0", overflow); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        for (int i = 1; i <= 17; i++) cycle(1'b1, DW'(i), 1'b0);
        for (int i = 0; i < 11; i++) cycle(1'b0, '0, 1'b1);
        n_checks++; if (fill_level !== 5'd5 || overflow !== 1'b1) $display("FAIL mid_pre got %0d/%b want 5/1", fill_level, overflow); else n_pass++;
        do_reset(1'b1);
        n_checks++; if (fill_level !== 5'd0) $display("FAIL mid_fill got %0d want 0", fill_level); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL mid_ovf got %b want 0", overflow); else n_pass++;
`ifdef NET_RX_STATS_EN
        n_checks++; if (drop_cnt !== 32'd0) $display("FAIL mid_dropcnt got %0d want 0", drop_cnt); else n_pass++;
`endif
    endtask

    task automatic test_random();
        do_reset(1'b0);
        for (int c = 0; c < 3000; c++) begin
            logic nv, rdy;
            if ($urandom_range(0, 299) == 0) do_reset($urandom_range(0, 1) == 1);
            n_checks++; if (fill_level !== (LD+1)'(mq.size())) $display("FAIL rnd_fill got %0d want %0d", fill_level, mq.size()); else n_pass++;
            n_checks++; if (out_valid !== (mq.size() > 0)) $display("FAIL rnd_valid got %b want %b", out_valid, mq.size() > 0); else n_pass++;
            n_checks++; if (overflow !== m_ovf) $display("FAIL rnd_ovf got %b want %b", overflow, m_ovf); else n_pass++;
            if (mq.size() > 0) begin
                n_checks++; if (out_data !== mq[0]) $display("FAIL rnd_data got %h want %h", out_data[63:0], mq[0][63:0]); else n_pass++;
            end
`ifdef NET_RX_STATS_EN
            n_checks++; if (drop_cnt !== m_drops) $display("FAIL rnd_dropcnt got %0d want %0d", drop_cnt, m_drops); else n_pass++;
`endif
            nv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 1) == 1);
            cycle(nv, rand_data(), rdy);
        end
    endtask

    initial begin
        reset     = 1'b1;
        net_valid = 1'b0;
        net_data  = '0;
        out_ready = 1'b0;
        m_ovf     = 1'b0;
        m_drops   = 32'd0;
        test_reset();
        test_single_beat();
        test_fill_drop();
        test_full_pop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
